park_lot_multi_gate: RTL and testbench

// - Parametrised successor to the single-gate parking lot controller.
// - Manages NUM_GATES entry/exit gate pairs that share one pool of CAPACITY spaces.
// - Each entry gate runs its own pay-then-open FSM and holds a slot reservation

---
 rtl/park_lot_multi_gate.sv | 118 +++++++++++
 tb/tb_park_lot_multi_gate.sv | 121 ++++++++++++
 2 files changed

// File: rtl/park_lot_multi_gate.sv
// park_lot_multi_gate: NUM_GATES entry/exit gate pairs sharing CAPACITY spaces, pay-then-open per entry gate
// Ports: clk, reset (async, active-high); Ent_Sens/Exit_Sens/paid_stat per gate (level);
//   Tick_1 1 Hz strobe; Red_State/Green_State per-gate lamps; Sev_indicator free spaces;
//   Full when no space is free; Timeout_Pulse per-gate abort strobe.
// Optional feature: define PARK_PAY_TIMEOUT_EN to build the payment timeout path.
module park_lot_multi_gate #(
  parameter int CAPACITY    = 9,
  parameter int NUM_GATES   = 2,
  parameter int CNT_W       = 4,
  parameter int PAY_TIMEOUT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] Ent_Sens,
  input  logic [NUM_GATES-1:0] Exit_Sens,
  input  logic                 Tick_1,
  input  logic [NUM_GATES-1:0] paid_stat,
  output logic [NUM_GATES-1:0] Red_State,
  output logic [NUM_GATES-1:0] Green_State,
  output logic [CNT_W-1:0]     Sev_indicator,
  output logic                 Full,
  output logic [NUM_GATES-1:0] Timeout_Pulse
);
  typedef enum logic [1:0] {IDLE, WAIT_PAY, OPEN} state_t;
  state_t state [NUM_GATES];
  state_t state_n [NUM_GATES];
  logic [NUM_GATES-1:0] ent_s, ent_d, exit_s, exit_d, ent_rise, ent_fall, exit_rise;
  logic [NUM_GATES-1:0] to, red_n, green_n, tp_n;
  logic [CNT_W-1:0] occ, resv, occ_n, resv_n, free;
  int avail, grants, aborts, commits, occ_v;
  assign ent_rise  = ent_s & ~ent_d;
  assign ent_fall  = ~ent_s & ent_d;
  assign exit_rise = exit_s & ~exit_d;
  assign free      = CNT_W'(CAPACITY - int'(occ) - int'(resv));
`ifdef PARK_PAY_TIMEOUT_EN
  localparam int TW = $clog2(PAY_TIMEOUT + 1);
  logic [TW-1:0] tcnt [NUM_GATES];
  // Counter saturates at PAY_TIMEOUT so a gate held in WAIT_PAY by payment cannot wrap.
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NUM_GATES; i++) tcnt[i] <= '0;
    else
      for (int i = 0; i < NUM_GATES; i++)
        tcnt[i] <= (state_n[i] == WAIT_PAY && state[i] != WAIT_PAY) ? '0 :
                   (state[i] == WAIT_PAY && Tick_1 && tcnt[i] != TW'(PAY_TIMEOUT)) ? tcnt[i] + 1'b1 : tcnt[i];
  always_comb
    for (int i = 0; i < NUM_GATES; i++) to[i] = tcnt[i] == TW'(PAY_TIMEOUT);
`else
  logic unused_tick;
  assign unused_tick = Tick_1;
  assign to = '0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NUM_GATES; i++) state[i] <= IDLE;
    else
      for (int i = 0; i < NUM_GATES; i++) state[i] <= state_n[i];
  // Grants are handed out in ascending gate order from the free count of the
  // registered occ/resv, so exits in this cycle never fund a grant in this cycle.
  always_comb begin
    avail   = CAPACITY - int'(occ) - int'(resv);
    grants  = 0;
    aborts  = 0;
    commits = 0;
    for (int i = 0; i < NUM_GATES; i++) begin
      state_n[i] = state[i];
      if (state[i] == IDLE && ent_rise[i] && avail > 0) begin
        state_n[i] = WAIT_PAY;
        avail--;
        grants++;
      end else if (state[i] == WAIT_PAY) begin
        if (paid_stat[i]) state_n[i] = OPEN;
        else if (!ent_s[i] || to[i]) begin
          state_n[i] = IDLE;
          aborts++;
        end
      end else if (state[i] == OPEN && ent_fall[i]) begin
        state_n[i] = IDLE;
        commits++;
      end
    end
    occ_v  = int'(occ) + commits - $countones(exit_rise);
    occ_n  = occ_v < 0 ? '0 : CNT_W'(occ_v);
    resv_n = CNT_W'(int'(resv) + grants - aborts - commits);
  end
  always_comb
    for (int i = 0; i < NUM_GATES; i++) begin
      red_n[i]   = state[i] != OPEN;
      green_n[i] = state[i] == OPEN;
      tp_n[i]    = state[i] == WAIT_PAY && !paid_stat[i] && ent_s[i] && to[i];
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ent_s         <= '0;
      ent_d         <= '0;
      exit_s        <= '0;
      exit_d        <= '0;
      occ           <= '0;
      resv          <= '0;
      Red_State     <= '1;
      Green_State   <= '0;
      Sev_indicator <= CNT_W'(CAPACITY);
      Full          <= 1'b0;
      Timeout_Pulse <= '0;
    end else begin
      ent_s         <= Ent_Sens;
      ent_d         <= ent_s;
      exit_s        <= Exit_Sens;
      exit_d        <= exit_s;
      occ           <= occ_n;
      resv          <= resv_n;
      Red_State     <= red_n;
      Green_State   <= green_n;
      Sev_indicator <= free;
      Full          <= free == '0;
      Timeout_Pulse <= tp_n;
    end
endmodule

// File: tb/tb_park_lot_multi_gate.sv
// tb_park_lot_multi_gate: directed scenario bench for park_lot_multi_gate (CAPACITY=9, NUM_GATES=2)
module tb_park_lot_multi_gate;
  logic clk = 0, reset = 1, Tick_1 = 0, Full;
  logic [1:0] Ent_Sens = 0, Exit_Sens = 0, paid_stat = 0, Red_State, Green_State, Timeout_Pulse;
  logic [3:0] Sev_indicator;
  int tests = 0, fails = 0, tp_cnt = 0, tp_base;
  park_lot_multi_gate dut (
    .clk(clk), .reset(reset), .Ent_Sens(Ent_Sens), .Exit_Sens(Exit_Sens), .Tick_1(Tick_1),
    .paid_stat(paid_stat), .Red_State(Red_State), .Green_State(Green_State),
    .Sev_indicator(Sev_indicator), .Full(Full), .Timeout_Pulse(Timeout_Pulse)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (Timeout_Pulse[0]) tp_cnt++;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic park(input int g);
    Ent_Sens[g] = 1; cyc(4);
    paid_stat[g] = 1; cyc(4);
    paid_stat[g] = 0; Ent_Sens[g] = 0; cyc(4);
  endtask
  task automatic leave(input int g);
    Exit_Sens[g] = 1; cyc(3);
    Exit_Sens[g] = 0; cyc(3);
  endtask
  task automatic test_reset;
    cyc(2);
    tests++; if (Red_State !== 2'b11) begin fails++; $display("FAIL reset_red got %b exp 11", Red_State); end
    tests++; if (Green_State !== 2'b00) begin fails++; $display("FAIL reset_green got %b exp 00", Green_State); end
    tests++; if (Sev_indicator !== 4'd9) begin fails++; $display("FAIL reset_sev got %0d exp 9", Sev_indicator); end
    tests++; if (Full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", Full); end
    tests++; if (Timeout_Pulse !== 2'b00) begin fails++; $display("FAIL reset_tp got %b exp 00", Timeout_Pulse); end
    reset = 0; cyc(2);
  endtask
  task automatic test_single_gate;
    Ent_Sens[0] = 1; cyc(4);
    tests++; if (Sev_indicator !== 4'd8) begin fails++; $display("FAIL single_resv_sev got %0d exp 8", Sev_indicator); end
    tests++; if (Red_State !== 2'b11 || Green_State !== 2'b00) begin fails++; $display("FAIL single_wait_lamps got r=%b g=%b exp r=11 g=00", Red_State, Green_State); end
    paid_stat[0] = 1; cyc(4);
    tests++; if (Green_State !== 2'b01 || Red_State !== 2'b10) begin fails++; $display("FAIL single_open_lamps got r=%b g=%b exp r=10 g=01", Red_State, Green_State); end
    paid_stat[0] = 0; Ent_Sens[0] = 0; cyc(4);
    tests++; if (Green_State !== 2'b00 || Red_State !== 2'b11) begin fails++; $display("FAIL single_pass_lamps got r=%b g=%b exp r=11 g=00", Red_State, Green_State); end
    tests++; if (Sev_indicator !== 4'd8) begin fails++; $display("FAIL single_pass_sev got %0d exp 8", Sev_indicator); end
  endtask
  task automatic test_exit_saturation;
    leave(0);
    tests++; if (Sev_indicator !== 4'd9) begin fails++; $display("FAIL exit_one_sev got %0d exp 9", Sev_indicator); end
    Exit_Sens = 2'b11; cyc(3);
    tests++; if (Sev_indicator !== 4'd9 || Full !== 1'b0) begin fails++; $display("FAIL exit_sat_sev got %0d full=%b exp 9 full=0", Sev_indicator, Full); end
    Exit_Sens = 2'b00; cyc(3);
    park(1);
    tests++; if (Sev_indicator !== 4'd8) begin fails++; $display("FAIL exit_sat_after_park got %0d exp 8", Sev_indicator); end
  endtask
  task automatic test_two_exits;
    park(0); park(1);
    tests++; if (Sev_indicator !== 4'd6) begin fails++; $display("FAIL two_exits_pre got %0d exp 6", Sev_indicator); end
    Exit_Sens = 2'b11; cyc(3);
    tests++; if (Sev_indicator !== 4'd8) begin fails++; $display("FAIL two_exits_post got %0d exp 8", Sev_indicator); end
    Exit_Sens = 2'b00; cyc(3);
    leave(0);
    tests++; if (Sev_indicator !== 4'd9) begin fails++; $display("FAIL two_exits_empty got %0d exp 9", Sev_indicator); end
  endtask
  task automatic test_contention;
    for (int k = 0; k < 8; k++) park(k % 2);
    tests++; if (Sev_indicator !== 4'd1 || Full !== 1'b0) begin fails++; $display("FAIL cont_pre got %0d full=%b exp 1 full=0", Sev_indicator, Full); end
    Ent_Sens = 2'b11; cyc(4);
    tests++; if (Sev_indicator !== 4'd0 || Full !== 1'b1) begin fails++; $display("FAIL cont_full got %0d full=%b exp 0 full=1", Sev_indicator, Full); end
    tests++; if (Red_State !== 2'b11 || Green_State !== 2'b00) begin fails++; $display("FAIL cont_lamps got r=%b g=%b exp r=11 g=00", Red_State, Green_State); end
    paid_stat[1] = 1; cyc(4);
    tests++; if (Green_State !== 2'b00) begin fails++; $display("FAIL cont_gate1_idle got g=%b exp 00", Green_State); end
    paid_stat[1] = 0; Ent_Sens[0] = 0; cyc(4);
    tests++; if (Sev_indicator !== 4'd1 || Full !== 1'b0) begin fails++; $display("FAIL cont_backaway got %0d full=%b exp 1 full=0", Sev_indicator, Full); end
    cyc(4);
    tests++; if (Sev_indicator !== 4'd1) begin fails++; $display("FAIL cont_no_retry got %0d exp 1", Sev_indicator); end
    Ent_Sens[1] = 0; cyc(4);
    for (int k = 0; k < 8; k++) leave(k % 2);
    tests++; if (Sev_indicator !== 4'd9) begin fails++; $display("FAIL cont_drain got %0d exp 9", Sev_indicator); end
  endtask
  task automatic test_timeout;
    tp_base = tp_cnt;
    Ent_Sens[0] = 1; cyc(4);
    for (int k = 0; k < 9; k++) begin Tick_1 = 1; cyc(1); Tick_1 = 0; cyc(2); end
    cyc(3);
    tests++; if (Sev_indicator !== 4'd8) begin fails++; $display("FAIL timeout_9_ticks got %0d exp 8", Sev_indicator); end
    Tick_1 = 1; cyc(1); Tick_1 = 0; cyc(5);
`ifdef PARK_PAY_TIMEOUT_EN
    tests++; if (Sev_indicator !== 4'd9) begin fails++; $display("FAIL timeout_release got %0d exp 9", Sev_indicator); end
    tests++; if (tp_cnt - tp_base !== 1) begin fails++; $display("FAIL timeout_pulse got %0d pulses exp 1", tp_cnt - tp_base); end
`else
    tests++; if (Sev_indicator !== 4'd8) begin fails++; $display("FAIL timeout_disabled_hold got %0d exp 8", Sev_indicator); end
    tests++; if (tp_cnt - tp_base !== 0) begin fails++; $display("FAIL timeout_disabled_pulse got %0d pulses exp 0", tp_cnt - tp_base); end
`endif
    tests++; if (Red_State !== 2'b11 || Green_State !== 2'b00) begin fails++; $display("FAIL timeout_lamps got r=%b g=%b exp r=11 g=00", Red_State, Green_State); end
    Ent_Sens[0] = 0; cyc(4);
    tests++; if (Sev_indicator !== 4'd9) begin fails++; $display("FAIL timeout_end got %0d exp 9", Sev_indicator); end
  endtask
  task automatic test_reset_mid;
    Ent_Sens[0] = 1; cyc(4);
    Ent_Sens[1] = 1; cyc(4);
    paid_stat[1] = 1; cyc(4);
    tests++; if (Sev_indicator !== 4'd7 || Green_State !== 2'b10) begin fails++; $display("FAIL mid_pre got %0d g=%b exp 7 g=10", Sev_indicator, Green_State); end
    reset = 1; #2;
    tests++; if (Sev_indicator !== 4'd9) begin fails++; $display("FAIL mid_reset_sev got %0d exp 9", Sev_indicator); end
    tests++; if (Green_State !== 2'b00 || Red_State !== 2'b11) begin fails++; $display("FAIL mid_reset_lamps got r=%b g=%b exp r=11 g=00", Red_State, Green_State); end
    Ent_Sens = 0; paid_stat = 0; cyc(2);
    reset = 0; cyc(4);
    tests++; if (Sev_indicator !== 4'd9 || Full !== 1'b0) begin fails++; $display("FAIL mid_after got %0d full=%b exp 9 full=0", Sev_indicator, Full); end
  endtask
  initial begin
    test_reset;
    test_single_gate;
    test_exit_saturation;
    test_two_exits;
    test_contention;
    test_timeout;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
